sn_drain_counter: RTL and testbench

Down-counting counterpart to the selector-gated up-counter in the arithmetic-cases suite. It accepts a preload value through a valid/ready handshake, then decrements the `sn`/`i` pair back to the reset point, one step per cycle while `selector` is high. It signals completion with a one-cycle `done` pulse. It is used to exercise and verify drain-side invariants: `i == sn + 1` and `sn <= LIMIT`.

---
 rtl/sn_drain_counter.sv | 120 ++++++++++++
 tb/tb_sn_drain_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sn_drain_counter.sv
// Preloadable down-counter: drains the sn/i pair back to 0/1 one step per selector-high cycle,
// with a one-cycle done pulse on completion and a one-cycle err pulse on an out-of-range preload.
module sn_drain_counter #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 70
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_val,
    output logic             load_ready,
    input  logic             selector,
    input  logic             abort,
    output logic [WIDTH-1:0] sn,
    output logic [WIDTH-1:0] i,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sn_q, sn_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rst_seen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sn_q    <= '0;
            i_q     <= ONE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sn_q    <= sn_d;
            i_q     <= i_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_seen_q <= 1'b1;
        end
    end

    // i is tracked as its own register so it moves in lockstep with sn rather than being derived.
    always_comb begin
        state_d = state_q;
        sn_d    = sn_q;
        i_d     = i_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    if (load_val <= LIMIT_W) begin
                        sn_d    = load_val;
                        i_d     = load_val + ONE;
                        state_d = (load_val != '0) ? DRAIN : DONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    sn_d    = '0;
                    i_d     = ONE;
                    state_d = IDLE;
                end else if (selector && (sn_q != '0)) begin
                    sn_d = sn_q - ONE;
                    i_d  = i_q - ONE;
                    if (sn_q == ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                sn_d    = '0;
                i_d     = ONE;
                state_d = IDLE;
            end
            default: begin
                sn_d    = '0;
                i_d     = ONE;
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == DRAIN);
    assign sn         = sn_q;
    assign i          = i_q;
    assign done       = done_q;
    assign err        = err_q;

    a_index_pair : assert property (@(posedge clk) disable iff (rst || !rst_seen_q)
        i_q == sn_q + ONE);
    a_sn_limit : assert property (@(posedge clk) disable iff (rst || !rst_seen_q)
        sn_q <= LIMIT_W);
    a_done_busy : assert property (@(posedge clk) disable iff (rst || !rst_seen_q)
        !(done_q && (state_q == DRAIN)));
    a_err_cause : assert property (@(posedge clk) disable iff (rst || !rst_seen_q)
        err_q |-> $past((state_q == IDLE) && load_valid && (load_val > LIMIT_W)));

endmodule

// File: tb/tb_sn_drain_counter.sv
// Directed bench for sn_drain_counter: an abstract count-based model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_sn_drain_counter;

    localparam int WIDTH = 16;
    localparam int LIMIT = 70;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             load_ready;
    logic             selector = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] sn;
    logic [WIDTH-1:0] i;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    sn_drain_counter #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_val   (load_val),
        .load_ready (load_ready),
        .selector   (selector),
        .abort      (abort),
        .sn         (sn),
        .i          (i),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Model: remaining count plus whether a drain is running or a completion is being reported.
    int m_sn      = 0;
    bit m_running = 0;
    bit m_finish  = 0;
    bit m_err     = 0;
    bit m_seen    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_sn = 0; m_running = 0; m_finish = 0; m_err = 0; m_seen = 1;
        end else if (m_finish) begin
            m_finish = 0; m_err = 0; m_sn = 0;
        end else if (!m_running) begin
            m_err = 0;
            if (load_valid) begin
                if (int'(load_val) > LIMIT) begin
                    m_err = 1;
                end else begin
                    m_sn = int'(load_val);
                    if (m_sn == 0) m_finish = 1;
                    else m_running = 1;
                end
            end
        end else begin
            m_err = 0;
            if (abort) begin
                m_sn = 0; m_running = 0;
            end else if (selector) begin
                m_sn = m_sn - 1;
                if (m_sn == 0) begin
                    m_running = 0; m_finish = 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_seen) begin
            checkOutput("model sn", int'(sn), m_sn);
            checkOutput("model i", int'(i), m_sn + 1);
            checkOutput("model busy", int'(busy), int'(m_running));
            checkOutput("model done", int'(done), int'(m_finish));
            checkOutput("model err", int'(err), int'(m_err));
            checkOutput("model load_ready", int'(load_ready), int'(!m_running && !m_finish));
        end
    end

    // Drives one cycle of inputs from a falling edge and returns at the next falling edge.
    task automatic applyStimulus(input bit lv, input int val, input bit sel, input bit ab, input bit r);
        load_valid = lv;
        load_val   = WIDTH'(val);
        selector   = sel;
        abort      = ab;
        rst        = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    int cnt;

    initial begin
        applyStimulus(1, 5, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("reset sn", int'(sn), 0);
        checkOutput("reset i", int'(i), 1);
        checkOutput("reset load_ready", int'(load_ready), 1);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset err", int'(err), 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] load 70, selector held high");
        applyStimulus(1, 70, 1, 0, 0);
        checkOutput("load70 sn", int'(sn), 70);
        checkOutput("load70 i", int'(i), 71);
        checkOutput("load70 busy", int'(busy), 1);
        cnt = 1;
        while (!done && cnt < 200) begin
            applyStimulus(0, 0, 1, 0, 0);
            cnt++;
        end
        checkOutput("load70 done latency", cnt, 71);
        checkOutput("load70 done busy", int'(busy), 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("load70 after done", int'(done), 0);
        checkOutput("load70 ready back", int'(load_ready), 1);

        $display("[TB] load 5, selector toggling");
        applyStimulus(1, 5, 0, 0, 0);
        cnt = 1;
        while (!done && cnt < 50) begin
            applyStimulus(0, 0, cnt[0], 0, 0);
            cnt++;
            if (cnt == 3) checkOutput("toggle sn after 2 cycles", int'(sn), 4);
        end
        checkOutput("toggle done latency", cnt, 10);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] reject 71, then load 0");
        applyStimulus(1, 71, 0, 0, 0);
        checkOutput("reject err", int'(err), 1);
        checkOutput("reject sn", int'(sn), 0);
        checkOutput("reject i", int'(i), 1);
        checkOutput("reject load_ready", int'(load_ready), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("reject err cleared", int'(err), 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("zero done", int'(done), 1);
        checkOutput("zero busy", int'(busy), 0);
        checkOutput("zero load_ready", int'(load_ready), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("zero ready back", int'(load_ready), 1);

        $display("[TB] load 20, abort at 12");
        applyStimulus(1, 20, 0, 0, 0);
        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("abort pre sn", int'(sn), 12);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("abort sn", int'(sn), 0);
        checkOutput("abort i", int'(i), 1);
        checkOutput("abort load_ready", int'(load_ready), 1);
        checkOutput("abort done", int'(done), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("abort no late done", int'(done), 0);

        $display("[TB] load 30, reset at 17");
        applyStimulus(1, 30, 0, 0, 0);
        for (int k = 0; k < 13; k++) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("reset-mid pre sn", int'(sn), 17);
        applyStimulus(1, 5, 1, 0, 1);
        checkOutput("reset-mid sn", int'(sn), 0);
        checkOutput("reset-mid i", int'(i), 1);
        checkOutput("reset-mid load_ready", int'(load_ready), 1);
        checkOutput("reset-mid busy", int'(busy), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("reset-mid no load", int'(sn), 0);

        $display("[TB] back-to-back loads of 3");
        applyStimulus(1, 3, 1, 0, 0);
        checkOutput("b2b first sn", int'(sn), 3);
        applyStimulus(1, 3, 1, 0, 0);
        applyStimulus(1, 3, 1, 0, 0);
        applyStimulus(1, 3, 1, 0, 0);
        checkOutput("b2b done", int'(done), 1);
        applyStimulus(1, 3, 1, 0, 0);
        checkOutput("b2b idle sn", int'(sn), 0);
        checkOutput("b2b idle ready", int'(load_ready), 1);
        applyStimulus(1, 3, 1, 0, 0);
        checkOutput("b2b second sn", int'(sn), 3);
        checkOutput("b2b second busy", int'(busy), 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
